// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver (LSB-first, 2-flop line synchronizer) feeding a
// first-word-fall-through receive FIFO. Define UART_RX_PARITY_EN to add the parity bit and check.
module uart_rx_fifo #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int DIV        = 163,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_data,
  input  logic                        i_rd,
  output logic [DBIT-1:0]             o_data,
  output logic                        o_ferr,
  output logic                        o_perr,
  output logic                        o_empty,
  output logic                        o_full,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_rx_done,
  output logic                        o_overrun
);
  localparam int TW = $clog2(DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_RX_PARITY_EN
  localparam int WW = DBIT + 2;
`else
  localparam int WW = DBIT + 1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic          sync1_reg, sync2_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic          tick;

  assign tick = (tick_cnt_reg == TW'(DIV - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      tick_cnt_reg <= '0;
    end else begin
      sync1_reg    <= i_data;
      sync2_reg    <= sync1_reg;
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TW'(1);
    end
  end

  state_t          state_reg, state_next;
  logic [4:0]      s_reg, s_next;
  logic [3:0]      n_reg, n_next;
  logic [DBIT-1:0] shift_reg, shift_next;
  logic            push;
  logic [WW-1:0]   push_word;
`ifdef UART_RX_PARITY_EN
  logic            perr_reg, perr_next;
  assign push_word = {perr_reg, ~sync2_reg, shift_reg};
`else
  assign push_word = {~sync2_reg, shift_reg};
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
      perr_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      shift_reg <= shift_next;
`ifdef UART_RX_PARITY_EN
      perr_reg  <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    shift_next = shift_reg;
    push       = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_next  = perr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!sync2_reg) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (tick) begin
          // Mid-start-bit recheck rejects glitches shorter than half a bit
          if (s_reg == 5'd7) begin
            state_next = sync2_reg ? IDLE : DATA;
            s_next     = '0;
            n_next     = '0;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_reg == 5'd15) begin
            s_next     = '0;
            shift_next = {sync2_reg, shift_reg[DBIT-1:1]};
            if (n_reg == 4'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_reg + 4'd1;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_reg == 5'd15) begin
            perr_next  = ((^shift_reg) ^ sync2_reg) != (PARITY_ODD != 0);
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_reg == 5'(SB_TICK - 1)) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full, empty, do_pop, do_push;
  logic [WW-1:0] head;

  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = i_rd && !empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the word
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge i_clock) begin
    if (i_reset && do_push) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head      = mem[rd_ptr_reg];
  assign o_data    = empty ? '0 : head[DBIT-1:0];
  assign o_ferr    = !empty && head[DBIT];
`ifdef UART_RX_PARITY_EN
  assign o_perr    = !empty && head[DBIT+1];
`else
  assign o_perr    = 1'b0;
`endif
  assign o_empty   = empty;
  assign o_full    = full;
  assign o_count   = count_reg;
  assign o_rx_done = push;
  assign o_overrun = push && full && !do_pop;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo: a slow instance (DIV=163) for the
// baud-accurate frame, a fast instance (DIV=4) sharing the same line for everything else.
module tb_uart_rx_fifo;
  localparam int DBIT     = 8;
  localparam int DEPTH    = 4;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int PAR_ODD  = 0;
  localparam int SLOW_DIV = 163;
  localparam int FAST_DIV = 4;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, line = 1'b1, rd = 1'b0, sel_slow = 1'b1;

  logic [DBIT-1:0] s_data, f_data, m_data;
  logic [CW-1:0]   s_count, f_count, m_count;
  logic s_ferr, s_perr, s_empty, s_full, s_done, s_ovf;
  logic f_ferr, f_perr, f_empty, f_full, f_done, f_ovf;
  logic m_ferr, m_perr, m_empty, m_full, m_done, m_ovf;

  uart_rx_fifo #(.DBIT(DBIT), .SB_TICK(16), .DIV(SLOW_DIV), .FIFO_DEPTH(DEPTH), .PARITY_ODD(PAR_ODD)) u_slow (
    .i_clock(clk), .i_reset(rst_n), .i_data(line), .i_rd(rd),
    .o_data(s_data), .o_ferr(s_ferr), .o_perr(s_perr), .o_empty(s_empty), .o_full(s_full),
    .o_count(s_count), .o_rx_done(s_done), .o_overrun(s_ovf));

  uart_rx_fifo #(.DBIT(DBIT), .SB_TICK(16), .DIV(FAST_DIV), .FIFO_DEPTH(DEPTH), .PARITY_ODD(PAR_ODD)) u_fast (
    .i_clock(clk), .i_reset(rst_n), .i_data(line), .i_rd(rd),
    .o_data(f_data), .o_ferr(f_ferr), .o_perr(f_perr), .o_empty(f_empty), .o_full(f_full),
    .o_count(f_count), .o_rx_done(f_done), .o_overrun(f_ovf));

  assign m_data  = sel_slow ? s_data  : f_data;
  assign m_count = sel_slow ? s_count : f_count;
  assign m_ferr  = sel_slow ? s_ferr  : f_ferr;
  assign m_perr  = sel_slow ? s_perr  : f_perr;
  assign m_empty = sel_slow ? s_empty : f_empty;
  assign m_full  = sel_slow ? s_full  : f_full;
  assign m_done  = sel_slow ? s_done  : f_done;
  assign m_ovf   = sel_slow ? s_ovf   : f_ovf;

  int errors = 0, checks = 0;
  int div = SLOW_DIV;
  int rx_done_seen = 0, ovf_seen = 0;
  bit mon_en = 1'b0, chk_after = 1'b0;
  word_t exp_q[$];   // frames on the wire awaiting their rx_done
  word_t fifo_q[$];  // reference FIFO contents

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit good_par(input logic [7:0] d);
    return bit'(($countones(d) + PAR_ODD) % 2);
  endfunction

  function automatic word_t model_frame(input logic [7:0] d, input bit stop_ok, input bit pbit);
    word_t w;
    w.data = d;
    w.ferr = !stop_ok;
`ifdef UART_RX_PARITY_EN
    w.perr = ((($countones(d) + int'(pbit)) % 2) != PAR_ODD);
`else
    w.perr = 1'b0;
    if (pbit) w.perr = 1'b0;
`endif
    return w;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every rx_done, pop and the cycle after either against the model
  always @(negedge clk) begin
    if (mon_en) begin
      word_t w;
      word_t h;
      bit popping;
      bit ovf_exp;
      if (chk_after) begin
        chk_after = 1'b0;
        chk("count", 32'(m_count), 32'(fifo_q.size()));
        chk("empty", 32'(m_empty), 32'(fifo_q.size() == 0));
        chk("full", 32'(m_full), 32'(fifo_q.size() == DEPTH));
        if (fifo_q.size() > 0) begin
          chk("head_data", 32'(m_data), 32'(fifo_q[0].data));
          chk("head_ferr", 32'(m_ferr), 32'(fifo_q[0].ferr));
          chk("head_perr", 32'(m_perr), 32'(fifo_q[0].perr));
        end else begin
          chk("empty_data", 32'(m_data), 32'd0);
        end
      end
      popping = rd && (fifo_q.size() > 0);
      if (rd && !popping) begin
        chk("pop_while_empty", 32'(m_empty), 32'd1);
        chk_after = 1'b1;
      end
      if (popping) begin
        h = fifo_q.pop_front();
        chk("pop_data", 32'(m_data), 32'(h.data));
        chk("pop_ferr", 32'(m_ferr), 32'(h.ferr));
        chk("pop_perr", 32'(m_perr), 32'(h.perr));
        $display("POP  data=%02h ferr=%0b perr=%0b", m_data, m_ferr, m_perr);
        chk_after = 1'b1;
      end
      if (m_done) begin
        rx_done_seen++;
        if (m_ovf) ovf_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rx_done", 32'(m_done), 32'd0);
        end else begin
          w = exp_q.pop_front();
          ovf_exp = ((fifo_q.size() + int'(popping)) == DEPTH) && !popping;
          chk("overrun", 32'(m_ovf), 32'(ovf_exp));
          if (!ovf_exp) fifo_q.push_back(w);
          $display("RX   data=%02h ferr=%0b perr=%0b overrun=%0b", w.data, w.ferr, w.perr, m_ovf);
          chk_after = 1'b1;
        end
      end else if (m_ovf) begin
        chk("spurious_overrun", 32'(m_ovf), 32'd0);
      end
    end
  end

  task automatic apply_reset();
    mon_en = 1'b0;
    line   = 1'b1;
    rd     = 1'b0;
    rst_n  = 1'b0;
    wait_clks(3);
    @(negedge clk);
    chk("rst_empty", 32'(m_empty), 32'd1);
    chk("rst_full", 32'(m_full), 32'd0);
    chk("rst_count", 32'(m_count), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_ferr", 32'(m_ferr), 32'd0);
    chk("rst_perr", 32'(m_perr), 32'd0);
    chk("rst_rx_done", 32'(m_done), 32'd0);
    chk("rst_overrun", 32'(m_ovf), 32'd0);
    $display("RST  empty=%0b count=%0d", m_empty, m_count);
    exp_q.delete();
    fifo_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    chk_after = 1'b0;
    mon_en    = 1'b1;
    wait_clks(2);
  endtask

  // abort_bit >= 0 stops mid-way through that data bit (the frame is never completed)
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit pbit, input int abort_bit);
    int bitc;
    bitc = 16 * div;
    if (abort_bit < 0) exp_q.push_back(model_frame(d, stop_ok, pbit));
    line = 1'b0;
    wait_clks(bitc);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      if (i == abort_bit) begin
        wait_clks(bitc / 2);
        return;
      end
      wait_clks(bitc);
    end
`ifdef UART_RX_PARITY_EN
    line = pbit;
    wait_clks(bitc);
`endif
    if (stop_ok) begin
      line = 1'b1;
      wait_clks(bitc);
    end else begin
      line = 1'b0;
      wait_clks(12 * div);
      line = 1'b1;
      wait_clks(4 * div);
    end
    line = 1'b1;
    wait_clks(bitc);
  endtask

  task automatic read_word();
    rd = 1'b1;
    wait_clks(1);
    rd = 1'b0;
    wait_clks(1);
  endtask

  task automatic drain();
    for (int g = 0; g < DEPTH + 1 && fifo_q.size() > 0; g++) read_word();
    read_word();
    chk("drain_empty", 32'(m_empty), 32'd1);
  endtask

  initial begin
    int base;
    int ovf_base;
    logic [7:0] d;
    bit ok;
    bit p;

    // Baud-accurate 8N1 frame on the DIV=163 instance
    sel_slow = 1'b1;
    div = SLOW_DIV;
    apply_reset();
    base = rx_done_seen;
    send_frame(8'h01, 1'b1, good_par(8'h01), -1);
    chk("slow_rx_done_pulses", 32'(rx_done_seen - base), 32'd1);
    chk("slow_pending", 32'(exp_q.size()), 32'd0);
    drain();

    sel_slow = 1'b0;
    div = FAST_DIV;
    apply_reset();

    // Start-bit glitch of 4 ticks must be rejected
    base = rx_done_seen;
    line = 1'b0;
    wait_clks(4 * div);
    line = 1'b1;
    wait_clks(32 * div);
    @(negedge clk);
    chk("glitch_no_rx_done", 32'(rx_done_seen - base), 32'd0);
    chk("glitch_empty", 32'(m_empty), 32'd1);

    // Framing error still stored, then popped
    send_frame(8'hA5, 1'b0, good_par(8'hA5), -1);
    read_word();
    chk("ferr_popped_empty", 32'(m_empty), 32'd1);

    // Fill past depth without reads
    ovf_base = ovf_seen;
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, good_par(8'h11 + 8'(i)), -1);
    @(negedge clk);
    chk("full_after_4", 32'(m_full), 32'd1);
    send_frame(8'h15, 1'b1, good_par(8'h15), -1);
    chk("overrun_pulses", 32'(ovf_seen - ovf_base), 32'd1);
    drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1, -1);
    send_frame(8'h03, 1'b1, 1'b0, -1);
    drain();
`endif

    // Randomized frames with occasional framing/parity errors and random reads
    for (int i = 0; i < 12; i++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      p  = good_par(d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, ok, p, -1);
      repeat ($urandom_range(0, 2)) read_word();
    end
    drain();
    chk("random_pending", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 4, then a clean frame
    send_frame(8'h3C, 1'b1, good_par(8'h3C), -1);
    send_frame(8'hC3, 1'b1, good_par(8'hC3), 4);
    apply_reset();
    wait_clks(32 * div);
    send_frame(8'h5A, 1'b1, good_par(8'h5A), -1);
    chk("post_reset_count", 32'(m_count), 32'd1);
    drain();
    chk("final_pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DBIT, default 8: data bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter SB_TICK, default 16: oversample ticks in the stop interval (16/24/32 = 1/1.5/2 stop bits).
REQ-003 The block SHALL have parameter DIV, default 163: clocks per oversample tick, minimum 2.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: receive FIFO words, power of two, minimum 2.
REQ-005 The block SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd; used only with UART_RX_PARITY_EN.
REQ-006 The block SHALL have port i_clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port i_reset, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have port i_data, input, 1 bit: asynchronous serial line, idle high.
REQ-009 The block SHALL have port i_rd, input, 1 bit: pop strobe, one word per cycle asserted.
REQ-010 The block SHALL have port o_data, output, DBIT bits: FIFO head word.
REQ-011 The block SHALL have ports o_ferr and o_perr, outputs, 1 bit each: frame and parity error flags stored with the head word.
REQ-012 The block SHALL have ports o_empty and o_full, outputs, 1 bit each: FIFO status.
REQ-013 The block SHALL have port o_count, output, clog2(FIFO_DEPTH)+1 bits: words held.
REQ-014 The block SHALL have ports o_rx_done and o_overrun, outputs, 1 bit each: one-cycle pulses.

Function
REQ-015 The block SHALL pass i_data through a two-flop synchronizer; all line decisions use the second flop.
REQ-016 The block SHALL free-run a tick counter 0..DIV-1, issuing a one-cycle tick when the count equals DIV-1, then wrapping to 0.
REQ-017 The block SHALL implement FSM states IDLE, START, DATA, PARITY and STOP; tick counter s and bit counter n advance only on ticks.
REQ-018 In IDLE, a synchronized low SHALL cause a transition to START with s=0.
REQ-019 In START, at s==7: if the line is low, the FSM SHALL go to DATA with s=0 and n=0; otherwise it SHALL return to IDLE (glitch reject, nothing pushed).
REQ-020 In DATA, at s==15 the FSM SHALL shift the line in LSB-first, clear s, and after bit DBIT-1 go to PARITY if enabled, otherwise to STOP.
REQ-021 In PARITY, at s==15 the FSM SHALL set perr = (XOR of data bits and parity bit) != PARITY_ODD, then go to STOP.
REQ-022 In STOP, at s==SB_TICK-1 the FSM SHALL set ferr = line low, push {perr, ferr, data} into the FIFO, pulse o_rx_done, and go to IDLE.
REQ-023 Frames with errors SHALL still be pushed, with their flags.
REQ-024 The FIFO SHALL be first-word-fall-through: o_data/o_ferr/o_perr show the head combinationally, and all three are 0 when empty.
REQ-025 A pop while empty SHALL be ignored.
REQ-026 A push while full without a same-cycle pop SHALL drop the word and pulse o_overrun for 1 cycle; o_rx_done SHALL still pulse.
REQ-027 A push and pop in the same cycle SHALL both take effect with o_count unchanged, including when full (no overrun).
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; o_full SHALL equal (o_count==FIFO_DEPTH) and o_empty SHALL equal (o_count==0).
REQ-029 Push-to-visible latency SHALL be 1 clock: the word appears on o_data the cycle after o_rx_done.

Reset
REQ-030 While i_reset is low at a clock edge, the block SHALL set FSM=IDLE, s, n and the tick counter to 0, synchronizer flops to 1, and pointers/count to 0, giving o_empty=1, o_full=0, o_count=0, o_data=0, o_ferr=0, o_perr=0, o_rx_done=0 and o_overrun=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; the next full frame after release SHALL be received correctly.

Configuration
REQ-032 With macro UART_RX_PARITY_EN defined, the PARITY state and parity check SHALL be compiled in.
REQ-033 Without UART_RX_PARITY_EN, the PARITY state SHALL be absent, DATA SHALL go directly to STOP, and o_perr SHALL be constant 0.

Verification
REQ-034 The bench SHALL check: reset, then 8N1 frame 0x01 at 2608 clocks/bit (DIV=163) -> one o_rx_done pulse; next cycle o_empty=0, o_data=0x01, o_ferr=0, o_count=1.
REQ-035 The bench SHALL check: line low for 4 ticks, then high -> no o_rx_done, o_empty stays 1, FSM back in IDLE.
REQ-036 The bench SHALL check: frame 0xA5 with stop bit 0 -> word 0xA5 stored with o_ferr=1; i_rd pulse -> o_empty=1.
REQ-037 The bench SHALL check: five frames 0x11..0x15 with FIFO_DEPTH=4 and no reads -> o_full=1 after the 4th, o_overrun pulse on the 5th; pops return 0x11..0x14 in order.
REQ-038 The bench SHALL check, with UART_RX_PARITY_EN and PARITY_ODD=0: 0x03 with parity bit 1 -> o_perr=1; with parity bit 0 -> o_perr=0.
REQ-039 The bench SHALL check: reset asserted during data bit 4 -> all outputs at reset values; a following 0x5A frame -> o_data=0x5A, no errors.
